p1v_io_ring: RTL and testbench



---
 rtl/p1v_io_pkg.sv | 22 ++
 rtl/p1v_io_debounce.sv | 44 ++++
 rtl/p1v_io_ring.sv | 135 +++++++++++++
 tb/tb_p1v_io_ring.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/p1v_io_pkg.sv
// Shared definitions for the p1v IO ring: reset FSM encoding, 160 MHz timing
// defaults and the counter-width helper.
package p1v_io_pkg;

  typedef enum logic [1:0] {
    ST_ASSERTED = 2'd0,
    ST_STRETCH  = 2'd1,
    ST_RUN      = 2'd2
  } rst_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1600000;  // 10 ms at 160 MHz
  localparam int DEF_STRETCH_CYCLES  = 160000;   // 1 ms at 160 MHz

  // Bits needed to hold a count of 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_DEBOUNCE_W = cnt_width(DEF_DEBOUNCE_CYCLES);
  localparam int DEF_STRETCH_W  = cnt_width(DEF_STRETCH_CYCLES);

endpackage

// File: rtl/p1v_io_debounce.sv
// Synchroniser plus debouncer for one raw active-low reset source; stable is
// the debounced level (0 means the source is requesting reset).
module p1v_io_debounce
  import p1v_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock_160,
  input  logic inp_res,
  input  logic raw_n,
  output logic stable
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_160 or posedge inp_res) begin
    if (inp_res) begin
      // NOTE: synchroniser and stable reset to 0 so every source counts as
      // holding reset until it has been seen high for the full debounce window.
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/p1v_io_ring.sv
// Pad/IO conditioning ring for the p1v core: pin synchronisers, output
// registers, LED drive and reset conditioning. Define PIN_GLITCH_FILTER_EN to add
// a 3-sample majority filter on every pin_in bit.
module p1v_io_ring
  import p1v_io_pkg::*;
#(
  parameter int NPINS           = 32,
  parameter int NRST            = 2,
  parameter int NLEDS           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int LED_ACTIVE_LOW  = 1
) (
  input  logic             clock_160,
  input  logic             inp_res,
  input  logic [NRST-1:0]  rst_src_n,
  output logic             res_out_n,
  input  logic [NPINS-1:0] pin_out,
  input  logic [NPINS-1:0] pin_dir,
  output logic [NPINS-1:0] pin_in,
  input  logic [NPINS-1:0] pad_in,
  output logic [NPINS-1:0] pad_out,
  output logic [NPINS-1:0] pad_oe,
  input  logic [NLEDS-1:0] cogled,
  output logic [NLEDS-1:0] led_pad
);

  localparam int               SW      = cnt_width(STRETCH_CYCLES);
  localparam logic [SW-1:0]    STR_MAX = SW'(STRETCH_CYCLES - 1);
  localparam logic [NLEDS-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? {NLEDS{1'b1}} : '0;

  // ---------------- pad <-> core data path ----------------
  logic [SYNC_STAGES-1:0][NPINS-1:0] pin_sync;
  logic [NPINS-1:0]                  pin_synced;

  assign pin_synced = pin_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_160 or posedge inp_res) begin
    if (inp_res) begin
      pin_sync <= '0;
      pad_out  <= '0;
      pad_oe   <= '0;
      led_pad  <= LED_OFF;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples the pre-edge value of its neighbours.
      pin_sync <= {pin_sync[SYNC_STAGES-2:0], pad_in};
      pad_out  <= pin_out;
      pad_oe   <= pin_dir;
      led_pad  <= cogled ^ LED_OFF;
    end
  end

`ifdef PIN_GLITCH_FILTER_EN
  logic [NPINS-1:0] flt_d1, flt_d2, flt_q;

  // Majority of the newest three synchronised samples drops 1-cycle pulses.
  always_ff @(posedge clock_160 or posedge inp_res) begin
    if (inp_res) begin
      flt_d1 <= '0;
      flt_d2 <= '0;
      flt_q  <= '0;
    end else begin
      flt_d1 <= pin_synced;
      flt_d2 <= flt_d1;
      flt_q  <= (pin_synced & flt_d1) | (pin_synced & flt_d2) | (flt_d1 & flt_d2);
    end
  end

  assign pin_in = flt_q;
`else
  assign pin_in = pin_synced;
`endif

  // ---------------- reset conditioning ----------------
  logic [NRST-1:0] stable;
  logic            req;

  for (genvar g = 0; g < NRST; g++) begin : g_rst
    p1v_io_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_160(clock_160),
      .inp_res  (inp_res),
      .raw_n    (rst_src_n[g]),
      .stable   (stable[g])
    );
  end

  assign req = ~&stable;

  rst_state_e    state;
  logic [SW-1:0] str_cnt;

  // res_out_n is registered alongside the state so it never glitches.
  always_ff @(posedge clock_160 or posedge inp_res) begin
    if (inp_res) begin
      state     <= ST_ASSERTED;
      str_cnt   <= '0;
      res_out_n <= 1'b0;
    end else begin
      case (state)
        ST_ASSERTED: begin
          if (!req) begin
            state   <= ST_STRETCH;
            str_cnt <= '0;
          end
        end
        ST_STRETCH: begin
          if (req) begin
            state <= ST_ASSERTED;
          end else if (str_cnt == STR_MAX) begin
            state     <= ST_RUN;
            res_out_n <= 1'b1;
          end else begin
            str_cnt <= str_cnt + SW'(1);
          end
        end
        ST_RUN: begin
          if (req) begin
            state     <= ST_ASSERTED;
            res_out_n <= 1'b0;
          end
        end
        default: begin
          state     <= ST_ASSERTED;
          res_out_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p1v_io_ring.sv
// Self-checking bench for p1v_io_ring: directed scenarios plus a randomized
// phase, all compared every clock against a behavioural model.
module tb_p1v_io_ring;

  localparam int NPINS = 32;
  localparam int NRST  = 2;
  localparam int NLEDS = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int STR   = 8;
  localparam int RISE  = SYNC + DEB + STR + 1;
`ifdef PIN_GLITCH_FILTER_EN
  localparam int PIN_LAT = SYNC + 1;
`else
  localparam int PIN_LAT = SYNC;
`endif

  logic             clock_160 = 1'b0;
  logic             inp_res;
  logic [NRST-1:0]  rst_src_n;
  logic             res_out_n;
  logic [NPINS-1:0] pin_out, pin_dir, pin_in, pad_in, pad_out, pad_oe;
  logic [NLEDS-1:0] cogled, led_pad;

  int errors = 0;
  int checks = 0;

  p1v_io_ring #(
    .NPINS(NPINS), .NRST(NRST), .NLEDS(NLEDS), .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .LED_ACTIVE_LOW(1)
  ) dut (
    .clock_160(clock_160), .inp_res(inp_res), .rst_src_n(rst_src_n),
    .res_out_n(res_out_n), .pin_out(pin_out), .pin_dir(pin_dir),
    .pin_in(pin_in), .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe),
    .cogled(cogled), .led_pad(led_pad)
  );

  always #5 clock_160 = ~clock_160;

  // ---------------- behavioural model ----------------
  logic [NPINS-1:0] m_ph [SYNC+3];   // pad_in sampled at the last edges, [0] newest
  logic [NRST-1:0]  m_sync [SYNC];
  logic [NRST-1:0]  m_stable;
  logic [DEB-1:0]   m_win [NRST];    // last DEB synchronised samples per source
  int               m_wn [NRST];
  int               m_quiet;         // consecutive edges that saw no reset request
  logic             m_res;
  logic [NPINS-1:0] m_pad_out, m_pad_oe;
  logic [NLEDS-1:0] m_led;

  task automatic model_reset();
    for (int i = 0; i < SYNC + 3; i++) m_ph[i] = '0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
    for (int s = 0; s < NRST; s++) begin m_win[s] = '0; m_wn[s] = 0; end
    m_stable = '0; m_quiet = 0; m_res = 1'b0;
    m_pad_out = '0; m_pad_oe = '0; m_led = '1;
  endtask

  task automatic model_step();
    // Core reset releases once the request has been absent for STR+1 edges.
    if (~&m_stable) m_quiet = 0;
    else            m_quiet++;
    m_res = (m_quiet >= STR + 1);
    // A source flips after DEB consecutive synchronised samples disagree with it.
    for (int s = 0; s < NRST; s++) begin
      m_win[s] = {m_win[s][DEB-2:0], m_sync[SYNC-1][s]};
      if (m_wn[s] < DEB) m_wn[s]++;
      if (m_wn[s] == DEB && m_win[s] == {DEB{~m_stable[s]}}) m_stable[s] = ~m_stable[s];
    end
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = rst_src_n;
    for (int i = SYNC + 2; i > 0; i--) m_ph[i] = m_ph[i-1];
    m_ph[0] = pad_in;
    m_pad_out = pin_out;
    m_pad_oe  = pin_dir;
    m_led     = ~cogled;
  endtask

  function automatic logic [NPINS-1:0] exp_pin_in();
`ifdef PIN_GLITCH_FILTER_EN
    return (m_ph[SYNC] & m_ph[SYNC+1]) | (m_ph[SYNC] & m_ph[SYNC+2]) |
           (m_ph[SYNC+1] & m_ph[SYNC+2]);
`else
    return m_ph[SYNC-1];
`endif
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pin_in",    64'(pin_in),    64'(exp_pin_in()));
    check("pad_out",   64'(pad_out),   64'(m_pad_out));
    check("pad_oe",    64'(pad_oe),    64'(m_pad_oe));
    check("led_pad",   64'(led_pad),   64'(m_led));
    check("res_out_n", 64'(res_out_n), 64'(m_res));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pin_in"},  64'(pin_in),    64'(0));
    check({tag, "_pad_out"}, 64'(pad_out),   64'(0));
    check({tag, "_pad_oe"},  64'(pad_oe),    64'(0));
    check({tag, "_led"},     64'(led_pad),   64'(8'hFF));
    check({tag, "_res"},     64'(res_out_n), 64'(0));
  endtask

  task automatic tick();
    @(posedge clock_160);
    if (inp_res) model_reset();
    else         model_step();
    #1;
    check_all();
  endtask

  // Ticks until res_out_n is 1, counting edges including the first one.
  task automatic wait_rise(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (res_out_n !== 1'b1 && n < 100);
    check(tag, 64'(n), 64'(RISE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NPINS-1:0] prev_pin;
    inp_res = 1'b1; rst_src_n = '1;
    pin_out = '0; pin_dir = '0; pad_in = '0; cogled = '0;
    model_reset();
    #1;
    check_reset_values("reset");
    repeat (3) tick();
    check_reset_values("reset_held");

    // Power-up release.
    inp_res = 1'b0;
    wait_rise("powerup_rise_cycles");
    repeat (3) tick();
    check("powerup_stays_high", 64'(res_out_n), 64'(1));

    // Short bounces on source 0 never reach the core reset.
    for (int b = 0; b < 5; b++) begin
      rst_src_n[0] = 1'b0; repeat (2) tick();
      rst_src_n[0] = 1'b1; repeat (3) tick();
    end
    check("bounce_ignored", 64'(res_out_n), 64'(1));

    // Real press, then release: full debounce plus stretch.
    rst_src_n[0] = 1'b0; repeat (6) tick();
    rst_src_n[0] = 1'b1;
    wait_rise("press_release_rise_cycles");

    // Re-assert source 1 so the request returns at stretch count 5.
    rst_src_n[0] = 1'b0; repeat (8) tick();
    check("press_low", 64'(res_out_n), 64'(0));
    rst_src_n[0] = 1'b1;
    for (int k = 0; k < 50 && !(&m_stable); k++) tick();
    rst_src_n[1] = 1'b0;
    repeat (8) tick();
    check("stretch_abort_low", 64'(res_out_n), 64'(0));
    rst_src_n[1] = 1'b1;
    wait_rise("stretch_repeat_rise_cycles");

    // Pin output and input paths.
    pin_dir = 32'h0000FFFF; pin_out = 32'hA5A5A5A5;
    tick();
    check("pad_oe_dir", 64'(pad_oe), 64'(32'h0000FFFF));
    check("pad_out_data", 64'(pad_out), 64'(32'hA5A5A5A5));
    prev_pin = pin_in;
    pad_in = 32'h12345678;
    repeat (PIN_LAT - 1) tick();
    check("pin_in_not_yet", 64'(pin_in), 64'(prev_pin));
    tick();
    check("pin_in_latency", 64'(pin_in), 64'(32'h12345678));

    // LEDs are active low.
    cogled = 8'b00000101;
    tick();
    check("led_polarity", 64'(led_pad), 64'(8'b11111010));

`ifdef PIN_GLITCH_FILTER_EN
    pad_in = '0; repeat (6) tick();
    pad_in[3] = 1'b1; tick();
    pad_in[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("glitch_filtered", 64'(pin_in[3]), 64'(0));
    end
`endif

    // Randomized traffic on every input, including overlapping reset sources.
    for (int k = 0; k < 400; k++) begin
      pin_out = $urandom(); pin_dir = $urandom(); pad_in = $urandom();
      cogled  = NLEDS'($urandom());
      for (int s = 0; s < NRST; s++)
        if ($urandom_range(15) == 0) rst_src_n[s] = ~rst_src_n[s];
      tick();
    end

    // Async reset in the middle of a debounce.
    pin_out = '1; pin_dir = '1; pad_in = '1; cogled = '1; rst_src_n = '1;
    for (int k = 0; k < 100 && !m_res; k++) tick();
    check("run_before_async", 64'(res_out_n), 64'(1));
    rst_src_n[0] = 1'b0;
    repeat (3) tick();
    inp_res = 1'b1;
    #1;
    check_reset_values("async_mid_debounce");
    model_reset();
    repeat (2) tick();

    // Async reset in the middle of the stretch.
    inp_res = 1'b0; rst_src_n = '1;
    for (int k = 0; k < 100 && m_quiet != 4; k++) tick();
    check("mid_stretch_low", 64'(res_out_n), 64'(0));
    inp_res = 1'b1;
    #1;
    check_reset_values("async_mid_stretch");
    model_reset();
    repeat (2) tick();
    inp_res = 1'b0;
    wait_rise("post_async_rise_cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
